gpio_wb: RTL and testbench

- Wishbone-slave general-purpose I/O block for the MPSoC peripheral set.
- Provides GPIO_WIDTH pins, each with:
  - an output register and an output-enable register;
  - an auxiliary-input multiplex;
  - a synchronised input sample;
  - edge-triggered interrupt generation.
- Sits on a 32-bit classic Wishbone bus and is driven by the bus-functional master in the block-level bench.

---
 rtl/gpio_wb.sv | 169 ++++++++++++++++
 tb/tb_gpio_wb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_wb.sv
// Wishbone classic slave GPIO block. It has per-pin output, output-enable, aux mux,
// a two-flop input synchroniser and edge-triggered interrupts.
module gpio_wb #(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned GPIO_WIDTH    = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_inta_o,
  input  logic [GPIO_WIDTH-1:0]    aux_i,
  input  logic [GPIO_WIDTH-1:0]    ext_pad_i,
  output logic [GPIO_WIDTH-1:0]    ext_pad_o,
  output logic [GPIO_WIDTH-1:0]    ext_padoe_o
);

  typedef enum logic [2:0] {
    REG_IN    = 3'd0,
    REG_OUT   = 3'd1,
    REG_OE    = 3'd2,
    REG_INTE  = 3'd3,
    REG_PTRIG = 3'd4,
    REG_AUX   = 3'd5,
    REG_CTRL  = 3'd6,
    REG_INTS  = 3'd7
  } reg_e;

  logic [GPIO_WIDTH-1:0]    out_q, out_d, oe_q, oe_d, inte_q, inte_d;
  logic [GPIO_WIDTH-1:0]    ptrig_q, ptrig_d, aux_q, aux_d, ints_q, ints_d;
  logic [GPIO_WIDTH-1:0]    sync1_q, sync1_d, in_q, in_d, prev_q, prev_d;
  logic                     ctrl_inte_q, ctrl_inte_d, ctrl_ints_q, ctrl_ints_d;
  logic                     ack_q, ack_d, err_q, err_d, inta_q, inta_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

  logic                     req, addr_ok, wr;
  reg_e                     reg_sel;
  logic [31:0]              byte_mask;
  logic [GPIO_WIDTH-1:0]    wmask, wdata, pin_event;

  // Only wb_adr_i[5:2] is decoded; the remaining address bits are intentionally ignored.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[WB_ADDR_WIDTH-1:6], wb_adr_i[1:0]};

  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old_v,
                                                  input logic [GPIO_WIDTH-1:0] new_v,
                                                  input logic [GPIO_WIDTH-1:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // NOTE: every *_d gets a default at the top of always_comb so no latch can be inferred.
  always_comb begin
    req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    addr_ok   = ~wb_adr_i[5];
    reg_sel   = reg_e'(wb_adr_i[4:2]);
    wr        = req & addr_ok & wb_we_i;
    byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wmask     = byte_mask[GPIO_WIDTH-1:0];
    wdata     = wb_dat_i[GPIO_WIDTH-1:0];

    sync1_d   = ext_pad_i;
    in_d      = sync1_q;
    prev_d    = in_q;
    pin_event = inte_q & ((ptrig_q & in_q & ~prev_q) | (~ptrig_q & ~in_q & prev_q));

    out_d       = out_q;
    oe_d        = oe_q;
    inte_d      = inte_q;
    ptrig_d     = ptrig_q;
    aux_d       = aux_q;
    ints_d      = ints_q;
    ctrl_inte_d = ctrl_inte_q;
    ctrl_ints_d = ctrl_ints_q;

    if (wr) begin
      case (reg_sel)
        REG_OUT:   out_d   = merge(out_q, wdata, wmask);
        REG_OE:    oe_d    = merge(oe_q, wdata, wmask);
        REG_INTE:  inte_d  = merge(inte_q, wdata, wmask);
        REG_PTRIG: ptrig_d = merge(ptrig_q, wdata, wmask);
        REG_AUX:   aux_d   = merge(aux_q, wdata, wmask);
        REG_INTS:  ints_d  = merge(ints_q, wdata, wmask);
        REG_CTRL: begin
          if (wb_sel_i[0]) begin
            ctrl_inte_d = wb_dat_i[0];
            ctrl_ints_d = wb_dat_i[1];
          end
        end
        default: ;
      endcase
    end

    // Hardware sets are applied after the bus write so a simultaneous set wins.
    ints_d = ints_d | pin_event;
    if (ctrl_inte_q && (|pin_event)) ctrl_ints_d = 1'b1;

    inta_d = ctrl_inte_q & ctrl_ints_q;
    ack_d  = req & addr_ok;
    err_d  = req & ~addr_ok;

    dat_d = '0;
    if (req && addr_ok) begin
      case (reg_sel)
        REG_IN:    dat_d = WB_DATA_WIDTH'(in_q);
        REG_OUT:   dat_d = WB_DATA_WIDTH'(out_q);
        REG_OE:    dat_d = WB_DATA_WIDTH'(oe_q);
        REG_INTE:  dat_d = WB_DATA_WIDTH'(inte_q);
        REG_PTRIG: dat_d = WB_DATA_WIDTH'(ptrig_q);
        REG_AUX:   dat_d = WB_DATA_WIDTH'(aux_q);
        REG_CTRL:  dat_d = WB_DATA_WIDTH'({ctrl_ints_q, ctrl_inte_q});
        REG_INTS:  dat_d = WB_DATA_WIDTH'(ints_q);
        default:   dat_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      out_q       <= '0;
      oe_q        <= '0;
      inte_q      <= '0;
      ptrig_q     <= '0;
      aux_q       <= '0;
      ints_q      <= '0;
      sync1_q     <= '0;
      in_q        <= '0;
      prev_q      <= '0;
      ctrl_inte_q <= 1'b0;
      ctrl_ints_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      inta_q      <= 1'b0;
      dat_q       <= '0;
    end else begin
      out_q       <= out_d;
      oe_q        <= oe_d;
      inte_q      <= inte_d;
      ptrig_q     <= ptrig_d;
      aux_q       <= aux_d;
      ints_q      <= ints_d;
      sync1_q     <= sync1_d;
      in_q        <= in_d;
      prev_q      <= prev_d;
      ctrl_inte_q <= ctrl_inte_d;
      ctrl_ints_q <= ctrl_ints_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      inta_q      <= inta_d;
      dat_q       <= dat_d;
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_inta_o   = inta_q;
  assign ext_pad_o   = (out_q & ~aux_q) | (aux_i & aux_q);
  assign ext_padoe_o = oe_q;

endmodule

// File: tb/tb_gpio_wb.sv
// Directed bench for gpio_wb: bus handshake, register map, pad mux, input sync,
// interrupts, error termination and reset during a pending access.
module tb_gpio_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o, wb_inta_o;
  logic [31:0] aux_i, ext_pad_i, ext_pad_o, ext_padoe_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_wb dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_inta_o  (wb_inta_o),
    .aux_i      (aux_i),
    .ext_pad_i  (ext_pad_i),
    .ext_pad_o  (ext_pad_o),
    .ext_padoe_o(ext_padoe_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus access starting at posedge+1; returns the cycle count to termination.
  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                     input logic [3:0] sel, output logic [31:0] rdat, output logic ack,
                     output logic err, output int lat);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) begin
        lat = i; ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick(1);
  endtask

  // Packs latency, terminations seen and the post-access idle state into one word.
  function automatic logic [31:0] hs(input int lat, input logic a, input logic e,
                                     input logic a_now, input logic e_now);
    return {20'd0, lat[7:0], a, e, a_now, e_now};
  endfunction

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] d,
                    input logic [3:0] sel);
    logic [31:0] r; logic a, e; int lat;
    bus(adr, 1'b1, d, sel, r, a, e, lat);
    check({tag, " hs"}, hs(lat, a, e, wb_ack_o, wb_err_o), hs(1, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r; logic a, e; int lat;
    bus(adr, 1'b0, 32'h0, 4'hF, r, a, e, lat);
    check({tag, " hs"}, hs(lat, a, e, wb_ack_o, wb_err_o), hs(1, 1'b1, 1'b0, 1'b0, 1'b0));
    check(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r; logic a, e; int lat;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
    aux_i = 0; ext_pad_i = 0; rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // 1: reset state
    check("rst pad_o", ext_pad_o, 32'h0);
    check("rst padoe", ext_padoe_o, 32'h0);
    check("rst inta", {31'd0, wb_inta_o}, 32'h0);
    check("rst dat_o", wb_dat_o, 32'h0);
    for (int i = 0; i < 8; i++) rd($sformatf("rst reg%0d", i), 32'(i * 4), 32'h0);

    // 2: output and output-enable, byte-lane write
    wr("wr out", 32'h04, 32'hA5A5A5A5, 4'hF);
    wr("wr oe", 32'h08, 32'hFFFF0000, 4'hF);
    check("pad_o", ext_pad_o, 32'hA5A5A5A5);
    check("padoe", ext_padoe_o, 32'hFFFF0000);
    rd("rd out", 32'h04, 32'hA5A5A5A5);
    rd("rd oe", 32'h08, 32'hFFFF0000);
    wr("wr out b0", 32'h04, 32'h11223344, 4'b0001);
    rd("rd out b0", 32'h04, 32'hA5A5A544);
    wr("wr out b2", 32'h04, 32'h11223344, 4'b0100);
    rd("rd out b2", 32'h04, 32'hA522A544);

    // 3: aux multiplex
    wr("wr aux", 32'h14, 32'h0000FFFF, 4'hF);
    aux_i = 32'h12345678;
    wr("wr out0", 32'h04, 32'h0, 4'hF);
    check("aux pad_o", ext_pad_o, 32'h00005678);
    rd("rd aux", 32'h14, 32'h0000FFFF);

    // 4: input synchroniser; the first read samples before the value has crossed
    ext_pad_i = 32'h0000003C;
    rd("in early", 32'h00, 32'h0);
    tick(2);
    rd("in late", 32'h00, 32'h0000003C);
    wr("wr in ign", 32'h00, 32'hFFFFFFFF, 4'hF);
    rd("in after wr", 32'h00, 32'h0000003C);

    // 5: rising-edge interrupt on pin 0
    wr("wr inte", 32'h0C, 32'h1, 4'hF);
    wr("wr ptrig", 32'h10, 32'h1, 4'hF);
    wr("wr ctrl", 32'h18, 32'h1, 4'hF);
    check("inta idle", {31'd0, wb_inta_o}, 32'h0);
    ext_pad_i = 32'h0000003D;
    tick(5);
    rd("ints set", 32'h1C, 32'h1);
    rd("ctrl set", 32'h18, 32'h3);
    check("inta set", {31'd0, wb_inta_o}, 32'h1);
    wr("clr ints", 32'h1C, 32'h0, 4'hF);
    wr("clr ctrl", 32'h18, 32'h1, 4'hF);
    tick(2);
    check("inta clr", {31'd0, wb_inta_o}, 32'h0);
    ext_pad_i = 32'h0000003C;
    tick(5);
    rd("ints fall", 32'h1C, 32'h0);
    rd("ctrl fall", 32'h18, 32'h1);
    check("inta fall", {31'd0, wb_inta_o}, 32'h0);

    // 6: error termination, no side effects
    bus(32'h20, 1'b0, 32'h0, 4'hF, r, a, e, lat);
    check("err rd hs", hs(lat, a, e, wb_ack_o, wb_err_o), hs(1, 1'b0, 1'b1, 1'b0, 1'b0));
    check("err rd dat", r, 32'h0);
    bus(32'h24, 1'b1, 32'hFFFFFFFF, 4'hF, r, a, e, lat);
    check("err wr hs", hs(lat, a, e, wb_ack_o, wb_err_o), hs(1, 1'b0, 1'b1, 1'b0, 1'b0));
    rd("out unchanged", 32'h04, 32'h0);
    check("pad_o unchanged", ext_pad_o, 32'h00005678);

    // Reset asserted while a request is pending: no termination appears
    wb_adr_i = 32'h04; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; rst_n = 1'b0;
    tick(1);
    check("rst pending", {30'd0, wb_ack_o, wb_err_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("rst pending ack", {30'd0, wb_ack_o, wb_err_o}, 32'h0);
    check("rst padoe2", ext_padoe_o, 32'h0);
    rd("rst aux2", 32'h14, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
